sync_gen: RTL and testbench

Frame/line timing generator feeding the pattern generator's `f_sync` and `sync` inputs. It produces a one-cycle frame-start pulse, then one one-cycle line-start pulse per line. Between pulses it runs programmable active, horizontal-blanking and vertical-blanking intervals, so the downstream counters see a well-formed frame. It supports single-shot and continuous frame generation, plus abort.

---
 rtl/sync_gen.sv | 227 ++++++++++++++++++++++
 tb/tb_sync_gen.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_gen.sv
// ---------------------------------------------------------------------------
// sync_gen
// Frame/line timing generator. Emits a one-cycle frame-start pulse, then for
// each line a one-cycle line-start pulse, an active window, and horizontal
// blanking. Vertical blanking follows the last line. Frames can be run one at
// a time or back-to-back, and dropping enable aborts a frame in progress.
//
// Parameters
//   LINE_LEN  active cycles per line            (1..4096)
//   LINES     lines per frame                   (1..32)
//   H_BLANK   idle cycles after each line       (0..255)
//   V_BLANK   idle cycles after the last line   (0..4095)
//
// Ports
//   clk         master clock (single domain)
//   rst         asynchronous, active-high reset
//   enable      generator enable; low returns to IDLE on the next edge
//   start       level request to begin a frame; ignored while busy
//   continuous  repeat frames; only looked at when a frame ends
//   f_sync      one-cycle frame-start pulse
//   sync        one-cycle line-start pulse
//   active      high during the LINE_LEN active cycles of each line
//   line_idx    current line, 0..LINES-1
//   frame_cnt   completed-frame counter, wraps at 256
//   busy        high in every state except IDLE
//   dbg_state   current FSM state encoding (IDLE=0, FSYNC=1, SYNC=2,
//               ACTIVE=3, HBLANK=4, VBLANK=5)
//
// Handshake: there is no valid/ready pair here. start is level-sampled on
// each rising edge while IDLE and enable is high; any other time it is
// dropped, never queued.
// ---------------------------------------------------------------------------
module sync_gen #(
    parameter int LINE_LEN = 4096,
    parameter int LINES    = 32,
    parameter int H_BLANK  = 16,
    parameter int V_BLANK  = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       start,
    input  logic       continuous,
    output logic       f_sync,
    output logic       sync,
    output logic       active,
    output logic [4:0] line_idx,
    output logic [7:0] frame_cnt,
    output logic       busy,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FSYNC  = 3'd1,
        S_SYNC   = 3'd2,
        S_ACTIVE = 3'd3,
        S_HBLANK = 3'd4,
        S_VBLANK = 3'd5
    } state_t;

    // Counter reload values: an interval of N cycles loads N-1 and the state
    // is left on the cycle the counter reads zero.
    localparam logic [12:0] LP_ACT_LOAD  = 13'(LINE_LEN - 1);
    localparam logic [12:0] LP_HB_LOAD   = 13'(H_BLANK - 1);
    localparam logic [12:0] LP_VB_LOAD   = 13'(V_BLANK - 1);
    localparam logic [4:0]  LP_LAST_LINE = 5'(LINES - 1);

    state_t      r_state;
    logic [12:0] r_cnt;
    logic [4:0]  r_line;
    logic [7:0]  r_frame;
    logic        r_f_sync;
    logic        r_sync;
    logic        r_active;
    logic        r_busy;

    state_t      w_nxt_state;
    logic [12:0] w_nxt_cnt;
    logic [4:0]  w_nxt_line;
    logic [7:0]  w_nxt_frame;

    // End-of-frame outcome, shared by VBLANK expiry and the V_BLANK=0 path.
    state_t      w_eof_state;
    logic [4:0]  w_eof_line;
    logic [7:0]  w_eof_frame;

    // End-of-line outcome, shared by HBLANK expiry and the H_BLANK=0 path.
    state_t      w_eol_state;
    logic [12:0] w_eol_cnt;
    logic [4:0]  w_eol_line;
    logic [7:0]  w_eol_frame;

    logic        w_cnt_zero;

    assign w_cnt_zero = (r_cnt == 13'd0);

    always_comb begin
        w_eof_frame = r_frame + 8'd1;
        if (continuous && enable) begin
            w_eof_state = S_FSYNC;
            w_eof_line  = 5'd0;
        end else begin
            w_eof_state = S_IDLE;
            w_eof_line  = r_line;
        end
    end

    always_comb begin
        w_eol_state = S_SYNC;
        w_eol_cnt   = 13'd0;
        w_eol_line  = r_line;
        w_eol_frame = r_frame;
        if (r_line < LP_LAST_LINE) begin
            w_eol_state = S_SYNC;
            w_eol_line  = r_line + 5'd1;
        end else if (V_BLANK != 0) begin
            w_eol_state = S_VBLANK;
            w_eol_cnt   = LP_VB_LOAD;
        end else begin
            w_eol_state = w_eof_state;
            w_eol_line  = w_eof_line;
            w_eol_frame = w_eof_frame;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_line  = r_line;
        w_nxt_frame = r_frame;
        if (!enable) begin
            // Abort: line_idx and frame_cnt hold so the partial frame is
            // visible afterwards; the frame is not counted.
            w_nxt_state = S_IDLE;
            w_nxt_cnt   = 13'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_nxt_cnt = 13'd0;
                    if (start) begin
                        w_nxt_state = S_FSYNC;
                        w_nxt_line  = 5'd0;
                    end
                end
                S_FSYNC: begin
                    w_nxt_state = S_SYNC;
                    w_nxt_cnt   = 13'd0;
                end
                S_SYNC: begin
                    w_nxt_state = S_ACTIVE;
                    w_nxt_cnt   = LP_ACT_LOAD;
                end
                S_ACTIVE: begin
                    if (!w_cnt_zero) begin
                        w_nxt_cnt = r_cnt - 13'd1;
                    end else if (H_BLANK != 0) begin
                        w_nxt_state = S_HBLANK;
                        w_nxt_cnt   = LP_HB_LOAD;
                    end else begin
                        w_nxt_state = w_eol_state;
                        w_nxt_cnt   = w_eol_cnt;
                        w_nxt_line  = w_eol_line;
                        w_nxt_frame = w_eol_frame;
                    end
                end
                S_HBLANK: begin
                    if (!w_cnt_zero) begin
                        w_nxt_cnt = r_cnt - 13'd1;
                    end else begin
                        w_nxt_state = w_eol_state;
                        w_nxt_cnt   = w_eol_cnt;
                        w_nxt_line  = w_eol_line;
                        w_nxt_frame = w_eol_frame;
                    end
                end
                S_VBLANK: begin
                    if (!w_cnt_zero) begin
                        w_nxt_cnt = r_cnt - 13'd1;
                    end else begin
                        w_nxt_state = w_eof_state;
                        w_nxt_cnt   = 13'd0;
                        w_nxt_line  = w_eof_line;
                        w_nxt_frame = w_eof_frame;
                    end
                end
                default: begin
                    w_nxt_state = S_IDLE;
                    w_nxt_cnt   = 13'd0;
                end
            endcase
        end
    end

    // State, counter and outputs in one register stage. Outputs are decoded
    // from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 13'd0;
            r_line   <= 5'd0;
            r_frame  <= 8'd0;
            r_f_sync <= 1'b0;
            r_sync   <= 1'b0;
            r_active <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_nxt_state;
            r_cnt    <= w_nxt_cnt;
            r_line   <= w_nxt_line;
            r_frame  <= w_nxt_frame;
            r_f_sync <= (w_nxt_state == S_FSYNC);
            r_sync   <= (w_nxt_state == S_SYNC);
            r_active <= (w_nxt_state == S_ACTIVE);
            r_busy   <= (w_nxt_state != S_IDLE);
        end
    end

    assign f_sync    = r_f_sync;
    assign sync      = r_sync;
    assign active    = r_active;
    assign busy      = r_busy;
    assign line_idx  = r_line;
    assign frame_cnt = r_frame;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_sync_gen.sv
// Bench for sync_gen. Two instances share the inputs: u_dut uses the small
// frame (LINE_LEN=4, LINES=2, H_BLANK=2, V_BLANK=3) and u_min the minimal one
// (1,1,0,0). Expected per-cycle output vectors
// {f_sync,sync,active,busy,line_idx,frame_cnt} are pushed when a frame is
// launched and popped one per cycle at the falling edge.
module tb_sync_gen;

  localparam int W = 17;

  logic clk;
  logic rst;
  logic enable;
  logic start;
  logic continuous;

  logic       f_sync1, sync1, active1, busy1;
  logic [4:0] line1;
  logic [7:0] fcnt1;
  logic [2:0] dbg1;

  logic       f_sync2, sync2, active2, busy2;
  logic [4:0] line2;
  logic [7:0] fcnt2;
  logic [2:0] dbg2;

  logic [W-1:0] vec1, vec2;
  logic [W-1:0] exp_q[$];

  int n_checks;
  int n_errors;

  assign vec1 = {f_sync1, sync1, active1, busy1, line1, fcnt1};
  assign vec2 = {f_sync2, sync2, active2, busy2, line2, fcnt2};

  sync_gen #(.LINE_LEN(4), .LINES(2), .H_BLANK(2), .V_BLANK(3)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start),
    .continuous(continuous), .f_sync(f_sync1), .sync(sync1),
    .active(active1), .line_idx(line1), .frame_cnt(fcnt1),
    .busy(busy1), .dbg_state(dbg1)
  );

  sync_gen #(.LINE_LEN(1), .LINES(1), .H_BLANK(0), .V_BLANK(0)) u_min (
    .clk(clk), .rst(rst), .enable(enable), .start(start),
    .continuous(continuous), .f_sync(f_sync2), .sync(sync2),
    .active(active2), .line_idx(line2), .frame_cnt(fcnt2),
    .busy(busy2), .dbg_state(dbg2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [W-1:0] obs,
                           input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got=%h want=%h", tag, $time, obs, exp);
    end
  endtask

  // Expected vector at cycle t (1-based) of a frame.
  function automatic logic [W-1:0] exp_frame(input int l, input int n,
      input int h, input int t, input logic [7:0] fc);
    int lp;
    int u;
    logic fs, sy, ac;
    logic [4:0] li;
    lp = 1 + l + h;
    u  = t - 2;
    fs = 1'b0;
    sy = 1'b0;
    ac = 1'b0;
    li = 5'd0;
    if (t == 1) begin
      fs = 1'b1;
    end else if (u < n * lp) begin
      li = 5'(u / lp);
      sy = ((u % lp) == 0);
      ac = ((u % lp) >= 1) && ((u % lp) <= l);
    end else begin
      li = 5'(n - 1);
    end
    return {fs, sy, ac, 1'b1, li, fc};
  endfunction

  task automatic push_frame(input int l, input int n, input int h,
                            input logic [7:0] fc, input int ncyc);
    for (int t = 1; t <= ncyc; t++) exp_q.push_back(exp_frame(l, n, h, t, fc));
  endtask

  task automatic push_idle(input int ncyc, input logic [4:0] li,
                           input logic [7:0] fc);
    for (int t = 0; t < ncyc; t++) exp_q.push_back({4'b0000, li, fc});
  endtask

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    continuous = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    check_val("reset_main", vec1, '0);
    check_val("reset_min", vec2, '0);
    rst = 1'b0;
  endtask

  // Raises start so the next rising edge is edge 0 of the frame.
  task automatic begin_frame();
    @(negedge clk);
    enable = 1'b1;
    start = 1'b1;
  endtask

  // Checks cycles 1..n; after checking cycle i the inputs for edge i are set.
  task automatic run_cycles(input int n, input bit sel, input string tag,
                            input int st_a, input int st_b,
                            input int en_off, input int cont_off);
    logic [W-1:0] exp;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL %s_underflow cycle=%0d got=%h want=<none>", tag, i,
                 sel ? vec2 : vec1);
      end else begin
        exp = exp_q.pop_front();
        check_val(tag, sel ? vec2 : vec1, exp);
      end
      start = (i == st_a) || (i == st_b);
      if (i == en_off) enable = 1'b0;
      if (i == cont_off) continuous = 1'b0;
    end
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_leftover got=%0d want=0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    enable = 1'b0;
    start = 1'b0;
    continuous = 1'b0;
    #2;
    check_val("por_main", vec1, '0);

    // single frame, start pulses during ACTIVE (4) and VBLANK (17) ignored
    do_reset();
    begin_frame();
    push_frame(4, 2, 2, 8'd0, 18);
    push_idle(3, 5'd1, 8'd1);
    run_cycles(21, 1'b0, "single", 4, 17, -1, -1);

    // continuous: f_sync at 1, 19, 37; continuous dropped in frame 3
    do_reset();
    continuous = 1'b1;
    begin_frame();
    push_frame(4, 2, 2, 8'd0, 18);
    push_frame(4, 2, 2, 8'd1, 18);
    push_frame(4, 2, 2, 8'd2, 18);
    push_idle(2, 5'd1, 8'd3);
    run_cycles(56, 1'b0, "cont", -1, -1, -1, 40);

    // abort in cycle 11, then restart from line 0
    do_reset();
    begin_frame();
    push_frame(4, 2, 2, 8'd0, 11);
    push_idle(3, 5'd1, 8'd0);
    run_cycles(14, 1'b0, "abort", -1, -1, 11, -1);
    begin_frame();
    push_frame(4, 2, 2, 8'd0, 18);
    push_idle(2, 5'd1, 8'd1);
    run_cycles(20, 1'b0, "restart", -1, -1, -1, -1);

    // asynchronous reset in cycle 10, then a fresh frame
    do_reset();
    begin_frame();
    push_frame(4, 2, 2, 8'd0, 9);
    run_cycles(9, 1'b0, "pre_rst", -1, -1, -1, -1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("rst_async", vec1, '0);
    @(negedge clk);
    rst = 1'b0;
    begin_frame();
    push_frame(4, 2, 2, 8'd0, 18);
    push_idle(2, 5'd1, 8'd1);
    run_cycles(20, 1'b0, "post_rst", -1, -1, -1, -1);

    // minimal frame, period 3, frame_cnt wraps 255 -> 0
    do_reset();
    continuous = 1'b1;
    begin_frame();
    for (int f = 0; f <= 256; f++) push_frame(1, 1, 0, 8'(f), 3);
    push_idle(2, 5'd0, 8'd1);
    run_cycles(773, 1'b1, "min", -1, -1, -1, 770);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
